// File: rtl/div_param.sv
// rtl/div_param.sv - parametrised multi-cycle restoring integer divider
//
// Purpose: signed/unsigned WIDTH-bit divide producing {remainder, quotient}.
//   One restoring step per cycle. A zero divisor is flagged instead of
//   divided. EX holds start_i high until ready_o, then drops it for at least
//   one cycle before the next request.
// Ports:
//   clk           system clock, rising edge
//   rst           asynchronous active-low reset
//   start_i       divide request, held for the whole operation
//   annul_i       abort the operation in flight
//   signed_div_i  1 = two's-complement operands
//   opdata1_i     dividend, sampled on the accepting edge
//   opdata2_i     divisor, sampled on the accepting edge
//   result_o      {remainder, quotient}, 0 unless ready_o
//   ready_o       result valid
//   busy_o        divider not idle
//   div_zero_o    result came from a zero divisor (qualified by ready_o)
// Optional feature macro: DIV_EARLY_TERM_EN (finish early when |divisor| > |dividend|)
module div_param #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               annul_i,
  input  logic               signed_div_i,
  input  logic [WIDTH-1:0]   opdata1_i,
  input  logic [WIDTH-1:0]   opdata2_i,
  output logic [2*WIDTH-1:0] result_o,
  output logic               ready_o,
  output logic               busy_o,
  output logic               div_zero_o
);

  typedef enum logic [1:0] {S_IDLE, S_BYZERO, S_ON, S_END} state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2*WIDTH:0]   work_q, work_d;
  logic [WIDTH-1:0]   dvsr_q, dvsr_d;
  logic               neg_quot_q, neg_quot_d;
  logic               neg_rem_q, neg_rem_d;
  logic               dz_q, dz_d;
  logic [2*WIDTH-1:0] result_q, result_d;
`ifdef DIV_EARLY_TERM_EN
  logic               early_q, early_d;
`endif

  // Operand magnitudes: MIN maps to 2^(WIDTH-1) as an unsigned value.
  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  assign dvd_neg = signed_div_i & opdata1_i[WIDTH-1];
  assign dvs_neg = signed_div_i & opdata2_i[WIDTH-1];
  assign dvd_mag = dvd_neg ? -opdata1_i : opdata1_i;
  assign dvs_mag = dvs_neg ? -opdata2_i : opdata2_i;

  // Restoring step: upper WIDTH+1 bits hold the partial remainder, lower
  // WIDTH bits shift the dividend out and the quotient bits in.
  logic [2*WIDTH:0] sh, step;
  logic [WIDTH:0]   diff;
  logic             ge;
  assign sh   = work_q << 1;
  assign ge   = sh[2*WIDTH:WIDTH] >= {1'b0, dvsr_q};
  assign diff = sh[2*WIDTH:WIDTH] - {1'b0, dvsr_q};
  assign step = ge ? {diff, sh[WIDTH-1:1], 1'b1} : sh;

  logic             last_step;
  logic [WIDTH-1:0] q_mag, r_mag, q_fix, r_fix;
  always_comb begin
    last_step = (cnt_q == CNT_W'(WIDTH - 1));
    q_mag     = step[WIDTH-1:0];
    // Final remainder is below the divisor, so the top bit is always zero.
    r_mag     = WIDTH'(step[2*WIDTH:WIDTH]);
`ifdef DIV_EARLY_TERM_EN
    // Early finish: quotient 0, remainder is the dividend magnitude still
    // sitting untouched in the low half of the working register.
    if (early_q) begin
      last_step = 1'b1;
      q_mag     = '0;
      r_mag     = work_q[WIDTH-1:0];
    end
`endif
    q_fix = neg_quot_q ? -q_mag : q_mag;
    r_fix = neg_rem_q  ? -r_mag : r_mag;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    work_d     = work_q;
    dvsr_d     = dvsr_q;
    neg_quot_d = neg_quot_q;
    neg_rem_d  = neg_rem_q;
    dz_d       = dz_q;
    result_d   = result_q;
`ifdef DIV_EARLY_TERM_EN
    early_d    = early_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          dvsr_d     = dvs_mag;
          work_d     = {{(WIDTH+1){1'b0}}, dvd_mag};
          cnt_d      = '0;
          neg_quot_d = dvd_neg ^ dvs_neg;
          neg_rem_d  = dvd_neg;
          dz_d       = (opdata2_i == '0);
          state_d    = (opdata2_i == '0) ? S_BYZERO : S_ON;
`ifdef DIV_EARLY_TERM_EN
          early_d    = (dvs_mag > dvd_mag);
`endif
        end
      end
      S_BYZERO: begin
        if (annul_i || !start_i) begin
          state_d = S_IDLE;
        end else begin
          result_d = '0;
          state_d  = S_END;
        end
      end
      S_ON: begin
        if (annul_i || !start_i) begin
          state_d = S_IDLE;
        end else begin
          work_d = step;
          cnt_d  = cnt_q + CNT_W'(1);
          if (last_step) begin
            result_d = {r_fix, q_fix};
            state_d  = S_END;
          end
        end
      end
      S_END: begin
        if (annul_i || !start_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      work_q     <= '0;
      dvsr_q     <= '0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      dz_q       <= 1'b0;
      result_q   <= '0;
`ifdef DIV_EARLY_TERM_EN
      early_q    <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      work_q     <= work_d;
      dvsr_q     <= dvsr_d;
      neg_quot_q <= neg_quot_d;
      neg_rem_q  <= neg_rem_d;
      dz_q       <= dz_d;
      result_q   <= result_d;
`ifdef DIV_EARLY_TERM_EN
      early_q    <= early_d;
`endif
    end
  end

  assign ready_o    = (state_q == S_END);
  assign busy_o     = (state_q != S_IDLE);
  assign result_o   = ready_o ? result_q : '0;
  assign div_zero_o = ready_o & dz_q;

endmodule
